// File: rtl/serial_word_loader.sv
// ----------------------------------------------------------------------------
// serial_word_loader
//
// Collects a serial bit stream into a `size`-bit word. The completed word is
// presented on data_out together with a one-cycle data_valid strobe, which a
// downstream register can use directly as its load enable.
//
// Parameters:
//   size      - word width in bits (>= 1)
//   msb_first - 1: the first received bit ends up in data_out[size-1]
//               0: the first received bit ends up in data_out[0]
//
// Ports:
//   ctrl       in   clock; all state changes on its rising edge
//   rst        in   asynchronous active-low reset
//   clear      in   synchronous abort of a partial word (highest priority)
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is sampled on this edge when high
//   data_out   out  last completed word, held until the next completion
//   data_valid out  one-cycle strobe following the edge that completed a word
//   busy       out  high while a partial word is held
//   bit_count  out  bits of the current partial word received so far
// ----------------------------------------------------------------------------
module serial_word_loader #(
    parameter int size      = 8,
    parameter bit msb_first = 1'b1,
    localparam int CW       = $clog2(size + 1)
) (
    input  logic            ctrl,
    input  logic            rst,
    input  logic            clear,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic [size-1:0] data_out,
    output logic            data_valid,
    output logic            busy,
    output logic [CW-1:0]   bit_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic [size-1:0]   r_shift;
    logic [CW-1:0]     r_count;
    logic [size-1:0]   r_data;
    logic              r_valid;

    // Word as it looks after absorbing the current bit_in.
    logic [size-1:0]   w_next_word;
    // Current bit is the last one of the word. For size == 1 the counter is
    // pinned at 0 and size-1 == 0, so every accepted bit completes a word.
    logic              w_last_bit;

    assign w_last_bit = (r_count == CW'(size - 1));

    generate
        if (size == 1) begin : g_single
            assign w_next_word = bit_in;
        end else if (msb_first) begin : g_msb
            // Shift left, new bit enters at bit 0.
            assign w_next_word = {r_shift[size-2:0], bit_in};
        end else begin : g_lsb
            // Shift right, new bit enters at the top bit.
            assign w_next_word = {bit_in, r_shift[size-1:1]};
        end
    endgenerate

    always_ff @(posedge ctrl or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (clear) begin
            // Abort wins over a simultaneous final bit; data_out is kept.
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (bit_valid) begin
            if (w_last_bit) begin
                r_data  <= w_next_word;
                r_valid <= 1'b1;
                r_shift <= '0;
                r_count <= '0;
                r_state <= IDLE;
            end else begin
                r_shift <= w_next_word;
                r_count <= r_count + 1'b1;
                r_valid <= 1'b0;
                r_state <= SHIFT;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = (r_state == SHIFT);
    assign bit_count  = r_count;

endmodule

// File: tb/tb_serial_word_loader.sv
// ----------------------------------------------------------------------------
// Testbench for serial_word_loader. Three instances are exercised one at a
// time: size=8 MSB-first, size=8 LSB-first and size=1. Expected words (with
// the cycle in which their data_valid must appear) are queued by the stimulus
// and checked by an independent monitor on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_serial_word_loader;

    logic ctrl = 1'b0;
    logic rst;
    logic clear;
    logic bit_in;
    logic bv;
    int   sel;        // 0 = MSB instance, 1 = LSB instance, 2 = size-1 instance
    int   cyc = 0;

    logic [7:0] dout_m, dout_l;
    logic [0:0] dout_1;
    logic       dv_m, dv_l, dv_1;
    logic       busy_m, busy_l, busy_1;
    logic [3:0] bc_m, bc_l;
    logic [0:0] bc_1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         s;
        logic [7:0] word;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    always #5 ctrl = ~ctrl;
    always @(posedge ctrl) cyc <= cyc + 1;

    serial_word_loader #(.size(8), .msb_first(1'b1)) u_msb (
        .ctrl(ctrl), .rst(rst), .clear(clear), .bit_in(bit_in),
        .bit_valid(bv && sel == 0),
        .data_out(dout_m), .data_valid(dv_m), .busy(busy_m), .bit_count(bc_m)
    );

    serial_word_loader #(.size(8), .msb_first(1'b0)) u_lsb (
        .ctrl(ctrl), .rst(rst), .clear(clear), .bit_in(bit_in),
        .bit_valid(bv && sel == 1),
        .data_out(dout_l), .data_valid(dv_l), .busy(busy_l), .bit_count(bc_l)
    );

    serial_word_loader #(.size(1), .msb_first(1'b1)) u_one (
        .ctrl(ctrl), .rst(rst), .clear(clear), .bit_in(bit_in),
        .bit_valid(bv && sel == 2),
        .data_out(dout_1), .data_valid(dv_1), .busy(busy_1), .bit_count(bc_1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] get_bc(input int s);
        if (s == 0) return {4'b0, bc_m};
        if (s == 1) return {4'b0, bc_l};
        return {7'b0, bc_1};
    endfunction

    function automatic logic get_busy(input int s);
        if (s == 0) return busy_m;
        if (s == 1) return busy_l;
        return busy_1;
    endfunction

    // Scoreboard monitor: every data_valid must match the head of the queue.
    task automatic mon(input int s, input logic dv, input logic [7:0] d);
        exp_t e;
        if (dv === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_valid: inst %0d data %h at cycle %0d, expected no strobe", s, d, cyc);
            end else begin
                e = sb.pop_front();
                if (e.s == s && e.word === d && e.cyc == cyc) begin
                    n_pass++;
                    $display("word inst=%0d data=%h cycle=%0d", s, d, cyc);
                end else begin
                    $display("FAIL word: inst %0d data %h cycle %0d, expected inst %0d data %h cycle %0d",
                             s, d, cyc, e.s, e.word, e.cyc);
                end
            end
        end
    endtask

    always @(negedge ctrl) begin
        mon(0, dv_m, dout_m);
        mon(1, dv_l, dout_l);
        mon(2, dv_1, {7'b0, dout_1});
    end

    task automatic send_bit(input logic b);
        bit_in = b;
        bv     = 1'b1;
        @(posedge ctrl);
        #1;
    endtask

    task automatic idle(input int n);
        bv = 1'b0;
        repeat (n) @(posedge ctrl);
        #1;
    endtask

    // Send the first n bits of 'bits' (bits[7] first) to an 8-bit instance,
    // checking bit_count/busy after each edge; optionally expect a word.
    task automatic send_seq(input int s, input logic [7:0] bits, input int n,
                            input logic push, input logic [7:0] expw);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            if (k == 8 && push) begin
                e.s = s; e.word = expw; e.cyc = cyc + 1;
                sb.push_back(e);
            end
            send_bit(bits[8-k]);
            if (k < 8) begin
                chk($sformatf("bit_count_%0d", k), get_bc(s), 8'(k));
                chk("busy_high", {7'b0, get_busy(s)}, 8'h01);
            end else begin
                chk("bit_count_wrap", get_bc(s), 8'h00);
                chk("busy_low", {7'b0, get_busy(s)}, 8'h00);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b0; clear = 1'b0; bit_in = 1'b0; bv = 1'b0; sel = 0;
        repeat (3) @(posedge ctrl);
        #1;
        chk("rst_data_out", dout_m, 8'h00);
        chk("rst_bit_count", {4'b0, bc_m}, 8'h00);
        chk("rst_busy", {7'b0, busy_m}, 8'h00);
        chk("rst_data_valid", {7'b0, dv_m}, 8'h00);
        rst = 1'b1;
        idle(2);

        // MSB-first 1,0,1,1,0,0,1,0 -> B2
        sel = 0;
        send_seq(0, 8'hB2, 8, 1'b1, 8'hB2);
        idle(3);

        // LSB-first, same bits -> 4D
        sel = 1;
        send_seq(1, 8'hB2, 8, 1'b1, 8'h4D);
        idle(3);

        // Gapped input then abort
        send_seq(1, 8'hE0, 3, 1'b0, 8'h00);
        bv = 1'b0;
        for (int g = 0; g < 5; g++) begin
            @(posedge ctrl); #1;
            chk("gap_bit_count", {4'b0, bc_l}, 8'h03);
        end
        clear = 1'b1;
        @(posedge ctrl); #1;
        clear = 1'b0;
        chk("abort_bit_count", {4'b0, bc_l}, 8'h00);
        chk("abort_busy", {7'b0, busy_l}, 8'h00);
        chk("abort_data_out", dout_l, 8'h4D);
        idle(3);

        // Clear on the same edge as the final bit
        sel = 0;
        send_seq(0, 8'hFE, 7, 1'b0, 8'h00);
        clear = 1'b1; bit_in = 1'b1; bv = 1'b1;
        @(posedge ctrl); #1;
        clear = 1'b0; bv = 1'b0;
        chk("clr_last_bit_count", {4'b0, bc_m}, 8'h00);
        chk("clr_last_busy", {7'b0, busy_m}, 8'h00);
        chk("clr_last_data_out", dout_m, 8'hB2);
        idle(3);
        send_seq(0, 8'hFF, 8, 1'b1, 8'hFF);
        idle(3);

        // Asynchronous reset between edges, mid-word
        send_seq(0, 8'hC0, 4, 1'b0, 8'h00);
        bv = 1'b0;
        @(negedge ctrl); #2;
        rst = 1'b0;
        #1;
        chk("arst_data_out", dout_m, 8'h00);
        chk("arst_bit_count", {4'b0, bc_m}, 8'h00);
        chk("arst_busy", {7'b0, busy_m}, 8'h00);
        chk("arst_data_valid", {7'b0, dv_m}, 8'h00);
        @(posedge ctrl); #1;
        rst = 1'b1;
        idle(1);
        send_seq(0, 8'h5A, 8, 1'b1, 8'h5A);
        idle(3);

        // Back-to-back words: strobes must land exactly 8 cycles apart
        send_seq(0, 8'hA5, 8, 1'b1, 8'hA5);
        send_seq(0, 8'h3C, 8, 1'b1, 8'h3C);
        idle(3);

        // size=1: every accepted bit is a word
        sel = 2;
        for (int k = 0; k < 3; k++) begin
            e.s = 2; e.word = (k == 1) ? 8'h00 : 8'h01; e.cyc = cyc + 1;
            sb.push_back(e);
            send_bit(e.word[0]);
            chk("s1_busy", {7'b0, busy_1}, 8'h00);
            chk("s1_bit_count", {7'b0, bc_1}, 8'h00);
            chk("s1_data_out", {7'b0, dout_1}, e.word);
        end
        idle(4);

        chk("scoreboard_empty", 8'(sb.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Upstream feeder stage for the sync_lib parametric register.
- Collects a serial bit stream into a `size`-bit word.
- Presents the completed word on `data_out` and emits a one-cycle `data_valid` strobe, which the downstream register uses as its load control.
- Provides a synchronous `clear` to abort a partial word, plus status outputs for the controlling logic.

Parameters:
- size, 8: word width in bits; legal range ≥ 1.
- msb_first, 1: 1 = first received bit lands in `data_out[size-1]`; 0 = first received bit lands in `data_out[0]`.

Ports:
- ctrl  in  1  clock; all state changes on posedge ctrl.
- rst  in  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of ctrl.
- clear  in  1  synchronous abort; discards any partial word.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  `bit_in` is sampled on this posedge when high.
- data_out  out  size  last completed word; held until the next completion.
- data_valid  out  1  one-cycle strobe; high in the cycle after the edge that completed a word.
- busy  out  1  high while a partial word is held (state SHIFT).
- bit_count  out  $clog2(size+1)  number of bits of the current partial word received so far (0..size-1).

Behaviour:
- Reset (rst=0, asynchronous) sets all outputs and internal state:
  - data_out = 0, data_valid = 0, busy = 0, bit_count = 0
  - internal shift register = 0, state = IDLE
- rst is released synchronously to ctrl by upstream logic; the first active edge after release behaves as in IDLE.
- States:
  - IDLE: no bits held.
  - SHIFT: 1..size-1 bits held.
- Edge evaluation, in priority order:
  1. clear=1:
     - shift register and bit_count go to 0; state goes to IDLE; data_valid goes to 0.
     - data_out is unchanged.
     - bit_valid is ignored on that edge.
  2. bit_valid=1, and this is the size-th bit of the word (bit_count == size-1, or size == 1):
     - data_out loads the completed word, including the current bit.
     - data_valid goes to 1 for the next cycle only.
     - bit_count goes to 0; state goes to IDLE.
  3. bit_valid=1, word not complete:
     - shift in bit_in; bit_count increments; state goes to SHIFT.
  4. bit_valid=0:
     - state, shift register and bit_count hold.
     - data_valid goes to 0.
- Bit placement:
  - msb_first=1: the word shifts left and the new bit enters at bit 0. After `size` bits, the first bit is in bit size-1.
  - msb_first=0: the word shifts right and the new bit enters at bit size-1. After `size` bits, the first bit is in bit 0.
- Latency: data_valid and the new data_out appear together, registered, one edge after the last bit is sampled.
- Throughput: with bit_valid held high continuously, a word completes every `size` cycles. data_valid pulses never merge.
- Gaps: idle cycles (bit_valid=0) between bits are unlimited. There is no timeout; the partial word is kept indefinitely.
- data_valid is never high for two consecutive cycles, except when size=1 and bit_valid is continuously high, where it stays high for each accepted bit.
- size=1: each accepted bit completes a word; state never enters SHIFT; busy stays 0.
- clear on the same edge as the final bit: the word is discarded, data_valid stays 0 and data_out keeps its previous value.
- Reset mid-word: the partial word is lost and data_out returns to 0.
- busy = (state == SHIFT).
- data_valid is a pure register output with no combinational path from any input.
- bit_count width is $clog2(size+1); for size=1 it is 1 bit wide and constantly 0.

Test Plan:
- Basic MSB-first: size=8, msb_first=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles → data_out=8'hB2; data_valid high for exactly one cycle, 1 edge after the 8th bit; busy=1 during bits 2..8 window.
- LSB-first: size=8, msb_first=0, same bit sequence → data_out=8'h4D, with one data_valid pulse.
- Gapped input with abort: send 3 bits, deassert bit_valid for 5 cycles, then clear=1 → bit_count returns 1,2,3,3..3,0; busy drops; data_out unchanged from its previous value (8'h4D); no data_valid.
- Simultaneous clear and last bit: 7 bits received, then bit_valid=1 and clear=1 on the same edge → no data_valid; data_out unchanged; bit_count=0. The next 8 bits 0xFF → data_out=8'hFF.
- Async reset mid-word: after 4 bits, pull rst low between edges → data_out, bit_count, busy and data_valid go to 0 immediately, without a clock edge. After release, a full word 0x5A loads correctly.
- Back-to-back and size=1:
  - size=8: 0xA5 then 0x3C streamed with no gap → two data_valid pulses exactly 8 cycles apart, with data_out 8'hA5 then 8'h3C.
  - size=1: bits 1,0,1 → data_out tracks 1,0,1 with data_valid high for 3 cycles.
